// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: core (c_*) and debug/loader (d_*)
// requesters, one transaction in flight, round-robin or core-first arbitration.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_CORE, OWN_DEBUG} owner_t;

  state_t        state, state_nx;
  owner_t        owner, last_owner, pick;
  logic [CW-1:0] cnt, cnt_nx;
  logic          start, capture;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] c_rdata_q, d_rdata_q;

  // On a tie the port that did not own the previous transaction wins, unless core-first.
  always_comb begin
    pick = OWN_CORE;
    if (c_req && d_req)
      pick = (FIXED_PRIO != 0 || last_owner == OWN_DEBUG) ? OWN_CORE : OWN_DEBUG;
    else if (d_req)
      pick = OWN_DEBUG;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (c_req || d_req) begin
          start    = 1'b1;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_nx   = CW'(MEM_LAT - 1);
        state_nx = S_WAIT;
      end
      // WAIT lasts MEM_LAT cycles; the last one is the cycle m_rdata is valid.
      S_WAIT: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_CORE;
      last_owner <= OWN_DEBUG;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (start) begin
      owner      <= pick;
      last_owner <= pick;
      we_q       <= (pick == OWN_CORE) ? c_we    : d_we;
      addr_q     <= (pick == OWN_CORE) ? c_addr  : d_addr;
      wdata_q    <= (pick == OWN_CORE) ? c_wdata : d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (capture && !we_q) begin
      if (owner == OWN_CORE) c_rdata_q <= m_rdata;
      else                   d_rdata_q <= m_rdata;
    end
  end

  assign c_gnt   = (state != S_IDLE) && (owner == OWN_CORE);
  assign d_gnt   = (state != S_IDLE) && (owner == OWN_DEBUG);
  assign c_done  = (state == S_DONE) && (owner == OWN_CORE);
  assign d_done  = (state == S_DONE) && (owner == OWN_DEBUG);
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = (state == S_ACCESS);
  assign m_we    = m_en & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances with different latency/priority settings, each with
// its own memory responder and a transaction-timeline reference model.
module tb_dmem_arbiter;
  localparam int NI = 4;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int fp_of(input int i);
    return (i == 3) ? 1 : 0;
  endfunction

  function automatic logic [31:0] init_word(input int idx);
    return 32'hC0DE_0000 | 32'(idx * 4);
  endfunction

  typedef struct {
    int          inst;
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   slot = 0;
  bit   model_on = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic        c_req [NI], c_we [NI], d_req [NI], d_we [NI];
  logic [31:0] c_addr [NI], c_wdata [NI], d_addr [NI], d_wdata [NI];
  logic        c_gnt [NI], c_done [NI], d_gnt [NI], d_done [NI], m_en [NI], m_we [NI];
  logic [31:0] c_rdata [NI], d_rdata [NI], m_addr [NI], m_wdata [NI];

  always #5 clk = ~clk;
  always @(posedge clk) slot <= slot + 1;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %h expected %h (slot %0d)", name, inst, act, exp, slot);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L  = lat_of(g);
    localparam int FP = fp_of(g);
    logic [31:0] m_rdata, junk;
    logic [31:0] mem [256];
    logic [31:0] pd [L];
    logic        pv [L];

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .FIXED_PRIO(FP)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_gnt(c_gnt[g]), .c_done(c_done[g]), .c_rdata(c_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_done(d_done[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata)
    );

    // Memory macro: read data appears L cycles after the m_en cycle, noise otherwise.
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      junk = '0;
    end
    always @(posedge clk) begin
      junk <= $urandom;
      if (m_en[g] && m_we[g]) mem[m_addr[g][9:2]] <= m_wdata[g];
      pv[0] <= m_en[g] && !m_we[g];
      pd[0] <= mem[m_addr[g][9:2]];
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
    assign m_rdata = pv[L-1] ? pd[L-1] : junk;

    // Reference: a transaction accepted at edge E owns the memory for slots E..E+L+1,
    // strobes in slot E, completes in slot E+L+1; the next request is taken at edge E+L+3.
    initial begin : sb
      int t, e, nxt;
      bit started, act, own_d, last_d, twe, in_txn, x_men, x_done;
      logic [31:0] taddr, twd, exp_c, exp_d;
      logic [31:0] shadow [256];
      started = 0; act = 0; own_d = 0; last_d = 1; twe = 0; e = 0; nxt = 0;
      taddr = '0; twd = '0; exp_c = '0; exp_d = '0;
      forever begin
        @(negedge clk);
        if (!model_on) begin
          started = 0;
        end else begin
          t = slot;
          if (!started) begin
            started = 1; act = 0; nxt = t + 1; last_d = 1; exp_c = '0; exp_d = '0;
            for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
          end
          in_txn = act && t >= e && t <= e + L + 1;
          x_men  = act && t == e;
          x_done = act && t == e + L + 1;
          if (x_men && twe) shadow[taddr[9:2]] = twd;
          if (x_done && !twe) begin
            if (own_d) exp_d = shadow[taddr[9:2]];
            else       exp_c = shadow[taddr[9:2]];
          end
          check("sb_c_gnt",  g, c_gnt[g],  in_txn && !own_d);
          check("sb_d_gnt",  g, d_gnt[g],  in_txn && own_d);
          check("sb_c_done", g, c_done[g], x_done && !own_d);
          check("sb_d_done", g, d_done[g], x_done && own_d);
          check("sb_m_en",   g, m_en[g],   x_men);
          if (x_men) begin
            check("sb_m_we", g, m_we[g], twe);
            if (twe) check("sb_m_wdata", g, m_wdata[g], twd);
          end
          if (in_txn && t <= e + L) check("sb_m_addr", g, m_addr[g], taddr);
          check("sb_c_rdata", g, c_rdata[g], exp_c);
          check("sb_d_rdata", g, d_rdata[g], exp_d);
          if (x_done) act = 0;
          if (t + 1 >= nxt && (c_req[g] || d_req[g])) begin
            if (c_req[g] && d_req[g]) own_d = (FP != 0) ? 1'b0 : !last_d;
            else                      own_d = d_req[g];
            last_d = own_d;
            e      = t + 1;
            nxt    = e + L + 3;
            act    = 1;
            twe    = own_d ? d_we[g]    : c_we[g];
            taddr  = own_d ? d_addr[g]  : c_addr[g];
            twd    = own_d ? d_wdata[g] : c_wdata[g];
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      c_req[i] = 0; c_we[i] = 0; c_addr[i] = '0; c_wdata[i] = '0;
      d_req[i] = 0; d_we[i] = 0; d_addr[i] = '0; d_wdata[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name, input int i);
    check({name, "_c_gnt"}, i, c_gnt[i], 0);
    check({name, "_d_gnt"}, i, d_gnt[i], 0);
    check({name, "_c_done"}, i, c_done[i], 0);
    check({name, "_d_done"}, i, d_done[i], 0);
    check({name, "_m_en"}, i, m_en[i], 0);
    check({name, "_m_we"}, i, m_we[i], 0);
    check({name, "_m_addr"}, i, m_addr[i], 0);
    check({name, "_m_wdata"}, i, m_wdata[i], 0);
    check({name, "_c_rdata"}, i, c_rdata[i], 0);
    check({name, "_d_rdata"}, i, d_rdata[i], 0);
  endtask

  // Single isolated transaction; request dropped and fields scrambled right after grant.
  task automatic run_vec(input vec_t v);
    int   i, L;
    logic own_gnt, own_done, other;
    i = v.inst;
    L = lat_of(i);
    step();
    if (v.dbg) begin
      d_req[i] = 1; d_we[i] = v.we; d_addr[i] = v.addr; d_wdata[i] = v.wdata;
    end else begin
      c_req[i] = 1; c_we[i] = v.we; c_addr[i] = v.addr; c_wdata[i] = v.wdata;
    end
    for (int k = 0; k <= L + 3; k++) begin
      @(negedge clk);
      own_gnt  = v.dbg ? d_gnt[i]  : c_gnt[i];
      own_done = v.dbg ? d_done[i] : c_done[i];
      other    = v.dbg ? (c_gnt[i] | c_done[i]) : (d_gnt[i] | d_done[i]);
      check("vec_m_en",  i, m_en[i],  k == 1);
      check("vec_gnt",   i, own_gnt,  k >= 1 && k <= L + 2);
      check("vec_done",  i, own_done, k == L + 2);
      check("vec_other", i, other,    0);
      if (k >= 1 && k <= L + 1) check("vec_m_addr", i, m_addr[i], v.addr);
      if (k == 1) begin
        check("vec_m_we", i, m_we[i], v.we);
        if (v.we) check("vec_m_wdata", i, m_wdata[i], v.wdata);
        c_req[i] = 0; d_req[i] = 0;
        c_we[i] = ~c_we[i]; d_we[i] = ~d_we[i];
        c_addr[i] = $urandom; d_addr[i] = $urandom;
        c_wdata[i] = $urandom; d_wdata[i] = $urandom;
      end
      if (k == L + 2) check("vec_rdata", i, v.dbg ? d_rdata[i] : c_rdata[i], v.exp_rdata);
    end
    clear_inputs();
  endtask

  initial begin
    vec_t vecs[$];
    int   seq[$];
    int   n_men0, n_done0, n_c3, n_d3, n_men3;
    bit   got;

    vecs.push_back('{0, 1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0});
    vecs.push_back('{0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 1'b1, 32'h40,  32'h12345678, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h40,  32'h0,        32'h12345678});
    vecs.push_back('{0, 1'b0, 1'b0, 32'h14,  32'h0,        32'hC0DE0014});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h14,  32'h0BADF00D, 32'hC0DE0014});
    vecs.push_back('{2, 1'b0, 1'b0, 32'h20,  32'h0,        32'hC0DE0020});
    vecs.push_back('{2, 1'b1, 1'b0, 32'h24,  32'h0,        32'hC0DE0024});
    vecs.push_back('{2, 1'b0, 1'b1, 32'h20,  32'hFFFFFFFF, 32'hC0DE0020});
    vecs.push_back('{2, 1'b0, 1'b0, 32'h20,  32'h0,        32'hFFFFFFFF});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'hC0DE03FC});
    vecs.push_back('{3, 1'b0, 1'b0, 32'h8,   32'h0,        32'hC0DE0008});

    rst = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_zero("reset", i);
    rst = 1'b1;

    foreach (vecs[j]) run_vec(vecs[j]);

    // Reset in the middle of a MEM_LAT=3 wait.
    step();
    c_req[1] = 1; c_addr[1] = 32'h3F0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_access_m_en", 1, m_en[1], 1);
    @(negedge clk);
    check("rstw_wait_gnt", 1, c_gnt[1], 1);
    check("rstw_wait_m_en", 1, m_en[1], 0);
    rst = 1'b0;
    #1;
    check_zero("rstw", 1);
    c_req[1] = 0;
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rstw_after_done", 1, c_done[1] | d_done[1], 0);
      check("rstw_after_busy", 1, c_gnt[1] | d_gnt[1] | m_en[1], 0);
    end
    run_vec('{1, 1'b0, 1'b0, 32'h3F8, 32'h0, 32'hC0DE03F8});

    // Both requests held from reset: round-robin on inst0, core-first on inst3.
    step();
    rst = 1'b0;
    c_req[0] = 1; d_req[0] = 1; c_addr[0] = 32'h10; d_addr[0] = 32'h40;
    c_req[3] = 1; d_req[3] = 1; c_addr[3] = 32'h8;  d_addr[3] = 32'hC;
    step();
    rst = 1'b1;
    n_men0 = 0; n_done0 = 0; n_c3 = 0; n_d3 = 0; n_men3 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c_done[0]) seq.push_back(0);
      if (d_done[0]) seq.push_back(1);
      if (m_en[0])   n_men0++;
      if (c_done[0]) n_done0++;
      if (d_done[0]) n_done0++;
      if (m_en[3])   n_men3++;
      if (c_done[3]) n_c3++;
      if (d_done[3]) n_d3++;
      check("tie_gnt_onehot0", 0, c_gnt[0] & d_gnt[0], 0);
      check("tie_gnt_onehot3", 3, c_gnt[3] & d_gnt[3], 0);
    end
    check("rr_done_count", 0, n_done0, 5);
    check("rr_m_en_count", 0, n_men0, 5);
    check("rr_seq_len", 0, seq.size(), 5);
    foreach (seq[j]) check("rr_order", 0, seq[j], j % 2);
    check("rr_c_rdata", 0, c_rdata[0], 32'hDEADBEEF);
    check("rr_d_rdata", 0, d_rdata[0], 32'h12345678);
    check("fp_core_done", 3, n_c3, 4);
    check("fp_dbg_done", 3, n_d3, 0);
    check("fp_m_en_count", 3, n_men3, 4);
    check("fp_c_rdata", 3, c_rdata[3], 32'hC0DE0008);
    step();
    c_req[0] = 0; d_req[0] = 0; c_req[3] = 0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_gnt[3]) d_req[3] = 0;
      if (d_done[3]) begin
        got = 1;
        check("fp_dbg_rdata", 3, d_rdata[3], 32'hC0DE000C);
      end
    end
    check("fp_dbg_served", 3, got, 1);
    clear_inputs();

    // Random traffic on all instances against the timeline model.
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        c_req[i]   = ($urandom_range(0, 99) < 55);
        d_req[i]   = ($urandom_range(0, 99) < 55);
        c_we[i]    = ($urandom_range(0, 2) == 0);
        d_we[i]    = ($urandom_range(0, 2) == 0);
        c_addr[i]  = 32'h200 | (32'($urandom_range(0, 15)) << 2);
        d_addr[i]  = 32'h200 | (32'($urandom_range(0, 15)) << 2);
        c_wdata[i] = $urandom;
        d_wdata[i] = $urandom;
      end
    end
    step();
    model_on = 1'b0;
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
